// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 SRAM slave: independent read/write FSMs, slave-side byte-lane shifting. Optional macro: AXI_SRAM_RAND_DELAY_EN.
// Latency: rvalid T+1+READ_LAT after AR, bvalid T+1+WRITE_LAT after the later of AW/W (+0..7 with AXI_SRAM_RAND_DELAY_EN).
// Backpressure: one access in flight per channel; rdata/rresp and bresp hold until rready/bready.
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic [1:0] access_resp(input logic [31:0] addr, input logic [2:0] size);
        if (addr < BASE_ADDR || ((addr - BASE_ADDR) >> 2) >= 32'(MEM_WORDS))
            return RESP_DECERR;
        if (size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [7:0] r_lat_load;
    logic [7:0] w_lat_load;
`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign r_lat_load = 8'(READ_LAT) + {5'd0, lfsr[2:0]};
    assign w_lat_load = 8'(WRITE_LAT) + {5'd0, lfsr[2:0]};
`else
    assign r_lat_load = 8'(READ_LAT);
    assign w_lat_load = 8'(WRITE_LAT);
`endif

    // ---------------- read channel ----------------
    r_state_t    r_state, r_state_nxt;
    logic [7:0]  r_cnt, r_cnt_nxt;
    logic [31:0] r_addr_q, r_addr_c, r_word, r_dat_c;
    logic [2:0]  r_size_q, r_size_c;
    logic [1:0]  r_resp_c;
    logic        r_latch, r_enter;

    // In R_IDLE the live AR fields are used so a zero-latency read can respond next cycle.
    assign r_addr_c = (r_state == R_IDLE) ? araddr : r_addr_q;
    assign r_size_c = (r_state == R_IDLE) ? arsize : r_size_q;
    assign r_resp_c = access_resp(r_addr_c, r_size_c);
    assign r_word   = mem[word_idx(r_addr_c)] >> {r_addr_c[1:0], 3'b000};
    assign r_enter  = (r_state != R_RESP) && (r_state_nxt == R_RESP);
    assign rvalid   = (r_state == R_RESP);

    always_comb begin
        r_dat_c = 32'd0;
        if (r_resp_c == RESP_OKAY) begin
            case (r_size_c)
                3'd0:    r_dat_c = {24'd0, r_word[7:0]};
                3'd1:    r_dat_c = {16'd0, r_word[15:0]};
                default: r_dat_c = r_word;
            endcase
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        r_cnt_nxt   = r_cnt;
        arready     = 1'b0;
        r_latch     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_latch     = 1'b1;
                    r_cnt_nxt   = r_lat_load;
                    r_state_nxt = (r_lat_load != 8'd0) ? R_WAIT : R_RESP;
                end
            end
            R_WAIT: begin
                r_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) r_state_nxt = R_RESP;
            end
            R_RESP: begin
                if (rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_cnt    <= 8'd0;
            r_addr_q <= 32'd0;
            r_size_q <= 3'd0;
            rdata    <= 32'd0;
            rresp    <= 2'b00;
        end else begin
            r_state <= r_state_nxt;
            r_cnt   <= r_cnt_nxt;
            if (r_latch) begin
                r_addr_q <= araddr;
                r_size_q <= arsize;
            end
            if (r_enter) begin
                rdata <= r_dat_c;
                rresp <= r_resp_c;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t         w_state, w_state_nxt;
    logic [7:0]       w_cnt, w_cnt_nxt;
    logic             aw_held, wd_held, aw_take, wd_take, w_enter, w_commit;
    logic [31:0]      w_addr_q, w_data_q, w_addr_c, w_data_c, w_old, w_new, lane_dat;
    logic [2:0]       w_size_q, w_size_c;
    logic [3:0]       w_strb_q, w_strb_c, lane_strb;
    logic [1:0]       w_resp_c;
    logic [IDX_W-1:0] w_idx;

    assign w_addr_c  = aw_held ? w_addr_q : awaddr;
    assign w_size_c  = aw_held ? w_size_q : awsize;
    assign w_data_c  = wd_held ? w_data_q : wdata;
    assign w_strb_c  = wd_held ? w_strb_q : wstrb;
    assign w_resp_c  = access_resp(w_addr_c, w_size_c);
    assign w_idx     = word_idx(w_addr_c);
    assign w_old     = mem[w_idx];
    assign lane_strb = w_strb_c << w_addr_c[1:0];
    assign lane_dat  = w_data_c << {w_addr_c[1:0], 3'b000};
    assign w_enter   = (w_state != W_RESP) && (w_state_nxt == W_RESP);
    // rst_n gate keeps a zero-latency write from landing while reset is held.
    assign w_commit  = rst_n && w_enter && (w_resp_c == RESP_OKAY);
    assign bvalid    = (w_state == W_RESP);

    always_comb begin
        w_new = w_old;
        for (int i = 0; i < 4; i++) begin
            if (lane_strb[i]) w_new[8*i +: 8] = lane_dat[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        w_cnt_nxt   = w_cnt;
        awready     = 1'b0;
        wready      = 1'b0;
        aw_take     = 1'b0;
        wd_take     = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !aw_held;
                wready  = !wd_held;
                aw_take = awvalid && !aw_held;
                wd_take = wvalid && !wd_held;
                if ((aw_held || aw_take) && (wd_held || wd_take)) begin
                    w_cnt_nxt   = w_lat_load;
                    w_state_nxt = (w_lat_load != 8'd0) ? W_WAIT : W_RESP;
                end
            end
            W_WAIT: begin
                w_cnt_nxt = w_cnt - 8'd1;
                if (w_cnt == 8'd1) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_cnt    <= 8'd0;
            aw_held  <= 1'b0;
            wd_held  <= 1'b0;
            w_addr_q <= 32'd0;
            w_size_q <= 3'd0;
            w_data_q <= 32'd0;
            w_strb_q <= 4'd0;
            bresp    <= 2'b00;
        end else begin
            w_state <= w_state_nxt;
            w_cnt   <= w_cnt_nxt;
            if (aw_take) begin
                aw_held  <= 1'b1;
                w_addr_q <= awaddr;
                w_size_q <= awsize;
            end
            if (wd_take) begin
                wd_held  <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (w_state == W_RESP && bready) begin
                aw_held <= 1'b0;
                wd_held <= 1'b0;
            end
            if (w_enter) bresp <= w_resp_c;
        end
    end

    // A read registering on the commit edge samples the pre-write word.
    always_ff @(posedge clk) begin
        if (w_commit) mem[w_idx] <= w_new;
    end
endmodule
